axis_queue_group: RTL



---
 rtl/axis_queue_group_pkg.sv | 25 ++
 rtl/axis_queue_group_if.sv | 38 +++
 rtl/axis_queue_group_rr_select.sv | 27 ++
 rtl/axis_queue_group.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/axis_queue_group_pkg.sv
// Shared definitions for the queue group: width derivation, RAM word layout
// and output queue selection encodings.
package axis_queue_group_pkg;

    localparam int QSEL_EXT = 0;
    localparam int QSEL_RR  = 1;

    function automatic int qw_of(input int num_queues);
        return $clog2(num_queues);
    endfunction

    function automatic int pw_of(input int depth);
        return $clog2(depth);
    endfunction

    function automatic int cw_of(input int depth);
        return $clog2(depth) + 1;
    endfunction

    // RAM word is {tlast, tdata}: tlast sits directly above the data bits.
    function automatic int word_w(input int data_width);
        return data_width + 1;
    endfunction

endpackage

// File: rtl/axis_queue_group_if.sv
// Stream-side signals of the queue group: write port, read port and the
// queue selectors that travel with them.
interface axis_queue_group_if
    import axis_queue_group_pkg::*;
#(
    parameter int NUM_QUEUES = 256,
    parameter int DATA_WIDTH = 8
) ();
    localparam int QW = qw_of(NUM_QUEUES);

    logic [DATA_WIDTH-1:0] s_axis_tdata;
    logic                  s_axis_tlast;
    logic                  s_axis_tvalid;
    logic                  s_axis_tready;
    logic [QW-1:0]         s_queue;
    logic                  s_queue_valid;

    logic [DATA_WIDTH-1:0] m_axis_tdata;
    logic                  m_axis_tlast;
    logic [QW-1:0]         m_axis_tid;
    logic                  m_axis_tvalid;
    logic                  m_axis_tready;
    logic [QW-1:0]         m_queue;
    logic                  m_queue_valid;

    modport slave (
        input  s_axis_tdata, s_axis_tlast, s_axis_tvalid, s_queue, s_queue_valid,
        input  m_axis_tready, m_queue, m_queue_valid,
        output s_axis_tready, m_axis_tdata, m_axis_tlast, m_axis_tid, m_axis_tvalid
    );

    modport master (
        output s_axis_tdata, s_axis_tlast, s_axis_tvalid, s_queue, s_queue_valid,
        output m_axis_tready, m_queue, m_queue_valid,
        input  s_axis_tready, m_axis_tdata, m_axis_tlast, m_axis_tid, m_axis_tvalid
    );

endinterface

// File: rtl/axis_queue_group_rr_select.sv
// Round-robin pick: first requesting queue strictly after last_i, wrapping.
// Rotate so that last_i+1 lands on bit 0, then take the lowest set bit.
module queue_rr_select
    import axis_queue_group_pkg::*;
#(
    parameter  int NUM_QUEUES = 256,
    localparam int QW         = qw_of(NUM_QUEUES)
) (
    input  logic [NUM_QUEUES-1:0] req_i,
    input  logic [QW-1:0]         last_i,
    output logic [QW-1:0]         grant_o,
    output logic                  valid_o
);
    logic [NUM_QUEUES-1:0] req_rot;
    logic [QW-1:0]         offset;

    always_comb begin
        req_rot = NUM_QUEUES'({req_i, req_i} >> (int'(last_i) + 1));
        offset  = '0;
        for (int i = NUM_QUEUES - 1; i >= 0; i--) begin
            if (req_rot[i]) offset = QW'(i);
        end
        grant_o = last_i + QW'(1) + offset;
        valid_o = |req_i;
    end

endmodule

// File: rtl/axis_queue_group.sv
// NUM_QUEUES logical AXI-Stream FIFOs sharing one partitioned RAM, with
// per-queue flush, occupancy query, non-empty bitmap and optional round-robin egress.
module axis_queue_group
    import axis_queue_group_pkg::*;
#(
    parameter  int NUM_QUEUES  = 256,
    parameter  int QUEUE_DEPTH = 16,
    parameter  int DATA_WIDTH  = 8,
    parameter  int LAST_ENABLE = 1,
    parameter  int OUT_MODE    = QSEL_EXT,
    localparam int QW          = qw_of(NUM_QUEUES),
    localparam int CW          = cw_of(QUEUE_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    axis_queue_group_if.slave     bus,
    input  logic [QW-1:0]         flush_queue,
    input  logic                  flush_valid,
    input  logic [QW-1:0]         stat_queue,
    output logic [CW-1:0]         stat_count,
    output logic [NUM_QUEUES-1:0] queue_nonempty
);
    localparam int            PW         = pw_of(QUEUE_DEPTH);
    localparam int            WW         = word_w(DATA_WIDTH);
    localparam int            AW         = QW + PW;
    localparam logic [CW-1:0] FULL_COUNT = CW'(QUEUE_DEPTH);
    localparam logic          LAST_EN    = (LAST_ENABLE != 0);

    logic [WW-1:0] ram [NUM_QUEUES*QUEUE_DEPTH];

    logic [CW-1:0] head_q [NUM_QUEUES];
    logic [CW-1:0] head_d [NUM_QUEUES];
    logic [CW-1:0] tail_q [NUM_QUEUES];
    logic [CW-1:0] tail_d [NUM_QUEUES];
    logic [QW-1:0] rr_last_q;

    logic                  m_tvalid_q;
    logic [DATA_WIDTH-1:0] m_tdata_q;
    logic                  m_tlast_q;
    logic [QW-1:0]         m_tid_q;
    logic [CW-1:0]         stat_count_q;

    logic [NUM_QUEUES-1:0] nonempty;
    logic [NUM_QUEUES-1:0] fetch_req;
    logic [CW-1:0]         s_count;
    logic                  s_ready;
    logic                  wr_fire;
    logic [QW-1:0]         rr_grant;
    logic                  rr_valid;
    logic [QW-1:0]         fetch_q;
    logic                  fetch_ok;
    logic                  fetch_fire;
    logic [AW-1:0]         rd_addr;
    logic [AW-1:0]         wr_addr;

    always_comb begin
        for (int q = 0; q < NUM_QUEUES; q++) nonempty[q] = (head_q[q] != tail_q[q]);
    end

    assign s_count = tail_q[bus.s_queue] - head_q[bus.s_queue];
    assign s_ready = bus.s_queue_valid && (s_count != FULL_COUNT) &&
                     !(flush_valid && (flush_queue == bus.s_queue));
    assign wr_fire = s_ready && bus.s_axis_tvalid;

    // Candidates use pre-write occupancy; a queue being flushed is never fetched.
    always_comb begin
        fetch_req = nonempty;
        if (flush_valid) fetch_req[flush_queue] = 1'b0;
    end

    queue_rr_select #(.NUM_QUEUES(NUM_QUEUES)) u_rr_select (
        .req_i   (fetch_req),
        .last_i  (rr_last_q),
        .grant_o (rr_grant),
        .valid_o (rr_valid)
    );

    always_comb begin
        if (OUT_MODE == QSEL_RR) begin
            fetch_q  = rr_grant;
            fetch_ok = rr_valid;
        end else begin
            fetch_q  = bus.m_queue;
            fetch_ok = bus.m_queue_valid && fetch_req[bus.m_queue];
        end
    end

    assign fetch_fire = (!m_tvalid_q || bus.m_axis_tready) && fetch_ok;
    assign rd_addr    = {fetch_q, head_q[fetch_q][PW-1:0]};
    assign wr_addr    = {bus.s_queue, tail_q[bus.s_queue][PW-1:0]};

    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        if (wr_fire)     tail_d[bus.s_queue] = tail_q[bus.s_queue] + CW'(1);
        if (fetch_fire)  head_d[fetch_q]     = head_q[fetch_q] + CW'(1);
        if (flush_valid) head_d[flush_queue] = tail_q[flush_queue];
    end

    always_ff @(posedge clk) begin
        if (wr_fire) ram[wr_addr] <= {bus.s_axis_tlast, bus.s_axis_tdata};
    end

    // The output register doubles as the RAM read register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int q = 0; q < NUM_QUEUES; q++) begin
                head_q[q] <= '0;
                tail_q[q] <= '0;
            end
            rr_last_q    <= QW'(NUM_QUEUES - 1);
            m_tvalid_q   <= 1'b0;
            m_tdata_q    <= '0;
            m_tlast_q    <= 1'b0;
            m_tid_q      <= '0;
            stat_count_q <= '0;
        end else begin
            head_q       <= head_d;
            tail_q       <= tail_d;
            stat_count_q <= tail_q[stat_queue] - head_q[stat_queue];
            if (fetch_fire) begin
                m_tvalid_q <= 1'b1;
                m_tdata_q  <= ram[rd_addr][DATA_WIDTH-1:0];
                m_tlast_q  <= ram[rd_addr][DATA_WIDTH] & LAST_EN;
                m_tid_q    <= fetch_q;
                if (OUT_MODE == QSEL_RR) rr_last_q <= fetch_q;
            end else if (bus.m_axis_tready) begin
                m_tvalid_q <= 1'b0;
            end
        end
    end

    assign bus.s_axis_tready = s_ready;
    assign bus.m_axis_tvalid = m_tvalid_q;
    assign bus.m_axis_tdata  = m_tdata_q;
    assign bus.m_axis_tlast  = m_tlast_q;
    assign bus.m_axis_tid    = m_tid_q;
    assign stat_count        = stat_count_q;
    assign queue_nonempty    = nonempty;

endmodule
